alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU signal bundle; slave is the arbiter's view, master the environment's.
interface alu_arbiter_if #(parameter int DATA_W = 8);
  logic [1:0]        ReqValid;
  logic [1:0]        ReqReady;
  logic [3:0]        ReqOp0;
  logic [3:0]        ReqOp1;
  logic [DATA_W-1:0] ReqA0;
  logic [DATA_W-1:0] ReqB0;
  logic [DATA_W-1:0] ReqA1;
  logic [DATA_W-1:0] ReqB1;
  logic [1:0]        RspValid;
  logic [1:0]        RspReady;
  logic [DATA_W-1:0] RspOut;
  logic              RspCarry;
  logic [3:0]        ALUOp;
  logic [DATA_W-1:0] AluA;
  logic [DATA_W-1:0] AluB;
  logic [DATA_W-1:0] AluOut;
  logic              AluCarry;

  modport slave (
    input  ReqValid, ReqOp0, ReqOp1, ReqA0, ReqB0, ReqA1, ReqB1, RspReady, AluOut, AluCarry,
    output ReqReady, RspValid, RspOut, RspCarry, ALUOp, AluA, AluB
  );

  modport master (
    output ReqValid, ReqOp0, ReqOp1, ReqA0, ReqB0, ReqA1, ReqB1, RspReady, AluOut, AluCarry,
    input  ReqReady, RspValid, RspOut, RspCarry, ALUOp, AluA, AluB
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared ALU; fixed priority (req0 wins) unless ALU_ARB_ROUND_ROBIN_EN is defined.
// Accept-to-RspValid is 2 cycles; requests stall (never drop) while a transaction is in ISSUE/RESP.
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input logic          CLK,
  input logic          RESET_N,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              gnt_q, gnt_d;
  logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              sel;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic              ptr_q, ptr_d;
`endif

  // sel is only meaningful when at least one request is valid
`ifdef ALU_ARB_ROUND_ROBIN_EN
  assign sel = (bus.ReqValid == 2'b11) ? ptr_q : ~bus.ReqValid[0];
`else
  assign sel = ~bus.ReqValid[0];
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = gnt_q;
    rsp_out_d   = rsp_out_q;
    rsp_carry_d = rsp_carry_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    alu_op      = 4'b0000;
    alu_a       = '0;
    alu_b       = '0;
    case (state_q)
      IDLE: begin
        if (|bus.ReqValid) begin
          req_ready = sel ? 2'b10 : 2'b01;
          op_d      = sel ? bus.ReqOp1 : bus.ReqOp0;
          a_d       = sel ? bus.ReqA1 : bus.ReqA0;
          b_d       = sel ? bus.ReqB1 : bus.ReqB0;
          gnt_d     = sel;
          state_d   = ISSUE;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          ptr_d     = ~sel;
`endif
        end
      end
      ISSUE: begin
        alu_op      = op_q;
        alu_a       = a_q;
        alu_b       = b_q;
        rsp_out_d   = bus.AluOut;
        rsp_carry_d = bus.AluCarry;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (bus.RspReady[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      op_q        <= 4'b0000;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= 1'b0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_out_q   <= rsp_out_d;
      rsp_carry_q <= rsp_carry_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // ReqReady is combinational from ReqValid, so it must also be squashed while reset is held
  assign bus.ReqReady = req_ready & {2{RESET_N}};
  assign bus.RspValid = rsp_valid;
  assign bus.RspOut   = rsp_out_q;
  assign bus.RspCarry = rsp_carry_q;
  assign bus.ALUOp    = alu_op;
  assign bus.AluA     = alu_a;
  assign bus.AluB     = alu_b;

endmodule
